// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative multiplier.
// Latency: none, wires only.
// Backpressure: none here; the requester must hold off while busy is high, and the unit ignores start while busy.
//
// Ports:
//   start   request pulse, only looked at while the unit is idle
//   op      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1     multiplicand
//   rs2     multiplier
//   busy    operation in flight
//   done    one-cycle pulse; result is valid
//   result  registered result, held until the next done
interface seq_multiplier_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Issue side: EX-stage control that launches multiplies.
    modport master (
        output start,
        output op,
        output rs1,
        output rs2,
        input  busy,
        input  done,
        input  result
    );

    // Execution side: the multiplier itself.
    modport slave (
        input  start,
        input  op,
        input  rs1,
        input  rs2,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), shift-add, one multiplier bit per cycle.
// Latency: start sampled at edge N, done pulses in the cycle after edge N+XLEN+1.
// Backpressure: busy stays high while in flight; start is ignored while busy, with no queuing.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low; aborts any operation in flight without a done pulse
//   bus    seq_multiplier_if slave: start/op/rs1/rs2 in, busy/done/result out

// One-bit full adder cell; XLEN of these form the accumulate ripple chain.
//
// Ports:
//   a, b, cin  addend bits and carry in
//   s, cout    sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_multiplier_if.slave   bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic              neg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     count;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // ------------------------------------------------------------------
    // Operand conditioning at issue: the core loop is an unsigned
    // multiply of magnitudes, the sign is re-applied once in FIX.
    // ------------------------------------------------------------------
    logic            rs1_signed;
    logic            rs2_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;

    assign rs1_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
    assign rs2_signed = (bus.op == OP_MULH);
    assign rs1_neg    = rs1_signed & bus.rs1[XLEN-1];
    assign rs2_neg    = rs2_signed & bus.rs2[XLEN-1];
    // Negating the most negative value yields the same bit pattern, which
    // read as unsigned is exactly 2^(XLEN-1), so no extra bit is needed.
    assign rs1_mag    = rs1_neg ? -bus.rs1 : bus.rs1;
    assign rs2_mag    = rs2_neg ? -bus.rs2 : bus.rs2;

    // ------------------------------------------------------------------
    // Partial-product add: upper accumulator half plus the multiplicand
    // (gated by the current multiplier LSB) through a ripple chain.
    // Each stage owns its carry so the chain is not one self-feeding vector.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] addend;
    logic [XLEN-1:0] add_sum;
    logic            add_cout;

    assign acc_hi = acc[2*XLEN-1:XLEN];
    assign addend = mplier[0] ? mcand : '0;

    for (genvar i = 0; i < XLEN; i++) begin : g_fa
        logic ci;
        logic co;
        if (i == 0) begin : g_lsb
            assign ci = 1'b0;
        end else begin : g_chain
            assign ci = g_fa[i-1].co;
        end
        full_adder u_fa (
            .a    (acc_hi[i]),
            .b    (addend[i]),
            .cin  (ci),
            .s    (add_sum[i]),
            .cout (co)
        );
    end

    assign add_cout = g_fa[XLEN-1].co;

    // Signed correction of the full-width product, applied in FIX.
    logic [2*XLEN-1:0] prod_fix;
    assign prod_fix = neg ? -acc : acc;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A start in the done cycle lands here, giving
                    // back-to-back issue with no bubble.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        mcand  <= rs1_mag;
                        mplier <= rs2_mag;
                        neg    <= rs1_neg ^ rs2_neg;
                        acc    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end

                CALC: begin
                    // Add result and carry shift down together; the low
                    // half of acc fills with finished product bits.
                    acc    <= {add_cout, add_sum, acc[XLEN-1:1]};
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    result_q <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0]
                                                 : prod_fix[2*XLEN-1:XLEN];
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative RV32M multiply unit in the EX stage, sitting next to the ALU.
- Executes MUL, MULH, MULHSU and MULHU using shift-add, retiring one multiplier bit per cycle.
- The per-cycle partial-product accumulation uses an XLEN-bit ripple chain of the team's fullAdder cells.
- Hazard logic stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand and result width. The iteration counter is $clog2(XLEN)+1 bits wide.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (rs1 signed × rs2 unsigned, high), 11 MULHU (u×u high)
- rs1  in  XLEN  multiplicand
- rs2  in  XLEN  multiplier
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when result is valid
- result  out  XLEN  registered result; held until the next done

Behaviour:
- Reset: on any clk edge with rst_n=0, go to IDLE. Outputs: busy=0, done=0, result=0. Clear the accumulator, counter and sign flag.
- Reset mid-operation: abort the operation; no done pulse is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - done defaults to 0 unless set by the FIX transition.
  - On the edge where start=1, latch op.
  - Latch |rs1| and |rs2|. Take the magnitude only for operands treated as signed: rs1 for MULH/MULHSU, rs2 for MULH only.
  - Set neg = sign(rs1_eff) XOR sign(rs2_eff), where an unsigned operand contributes sign 0.
  - Clear the 2×XLEN accumulator, set count=0, go to CALC, set busy=1.
- CALC, one iteration per edge:
  - If the multiplier LSB is 1, add the multiplicand to the upper XLEN bits of the accumulator through the fullAdder chain, keeping the carry-out as bit 2×XLEN.
  - Shift {carry, acc} right by 1 and shift the multiplier right by 1.
  - Increment count. After XLEN iterations go to FIX.
- FIX, single edge:
  - If neg=1, take the two's complement of the 2×XLEN product.
  - result = low half for MUL, high half otherwise.
  - done=1, busy=0, go to IDLE.
- Latency:
  - start sampled at edge N → done high for exactly the cycle following edge N+XLEN+1 (N+33 for XLEN=32).
  - busy is high from edge N through edge N+XLEN+1 and falls on the same edge that done rises.
- Handshake:
  - start while busy=1 is ignored, with no queuing.
  - start in the cycle done=1 (state IDLE) is accepted, giving back-to-back issue with no bubble.
  - A new operation does not clear result until its own FIX edge.
- Arithmetic:
  - The product is exact over 2×XLEN bits, with no overflow flag.
  - The magnitude of 0x80000000 is represented correctly as unsigned 2^31.
  - A zero operand still takes the full latency.
- Operands are captured at start. Later changes on rs1, rs2 or op have no effect.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-CALC, then release → busy=0, done=0, result=0, no spurious done. A fresh start afterwards completes normally.
- MUL signed wrap: rs1=7, rs2=0xFFFFFFFD → after 33 cycles result=0xFFFFFFEB with a single-cycle done. Also rs1=0, rs2=0x12345678 → 0x00000000 at the same latency.
- MULH corner: rs1=rs2=0x80000000 → result=0x40000000. Also rs1=0xFFFFFFFF, rs2=1 (MULH) → 0xFFFFFFFF.
- MULHSU / MULHU:
  - rs1=0xFFFFFFFF, rs2=0xFFFFFFFF with op=10 → 0xFFFFFFFF.
  - Same operands with op=11 → 0xFFFFFFFE.
- Handshake: pulse start again at cycles 5 and 20 while busy → ignored, result matches the first operation. Then issue start in the done cycle → second result arrives exactly 33 cycles later.
- Random: 10k random op/rs1/rs2 against a 64-bit reference model → every result matches; busy/done timing is checked every cycle.
